// File: rtl/wr_fifo_arbiter.sv
// Round-robin arbiter feeding two-beat write bursts from two requesters into the DDR af/wdf FIFOs.
// Optional burst/stall counters are enabled with `define WRARB_PERF_CNT_EN.
module wr_fifo_arbiter #(
  parameter int ADDR_W = 31,
  parameter int DATA_W = 128,
  parameter int MASK_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_valid,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [2*DATA_W-1:0] r0_data,
  input  logic [2*MASK_W-1:0] r0_mask,
  output logic                r0_ack,
  input  logic                r1_valid,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [2*DATA_W-1:0] r1_data,
  input  logic [2*MASK_W-1:0] r1_mask,
  output logic                r1_ack,
  input  logic                af_full,
  input  logic                wdf_full,
  output logic [ADDR_W-1:0]   af_addr_din,
  output logic                af_wr_en,
  output logic [DATA_W-1:0]   wdf_din,
  output logic [MASK_W-1:0]   wdf_mask_din,
  output logic                wdf_wr_en,
`ifdef WRARB_PERF_CNT_EN
  output logic [31:0]         r0_burst_cnt,
  output logic [31:0]         r1_burst_cnt,
  output logic [31:0]         stall_cnt,
`endif
  output logic                busy,
  output logic                gnt_id
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last;
  logic                  r_gnt_id;
  logic [ADDR_W-1:0]     r_addr;
  logic [2*DATA_W-1:0]   r_data;
  logic [2*MASK_W-1:0]   r_mask;

  logic                  w_push0;
  logic                  w_push1;
  logic                  w_arb_en;
  logic                  w_grant;
  logic                  w_gnt_sel;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_push0     = 1'b0;
    w_push1     = 1'b0;
    w_state_nxt = r_state;
    w_push0  = (r_state == ST_BEAT0) & ~af_full & ~wdf_full;
    w_push1  = (r_state == ST_BEAT1) & ~wdf_full;
    // Acks are combinational, so they must be held off while reset is asserted.
    w_arb_en  = ~rst & ((r_state == ST_IDLE) | w_push1);
    w_grant   = w_arb_en & (r0_valid | r1_valid);
    w_gnt_sel = (r0_valid & r1_valid) ? ~r_last : r1_valid;

    case (r_state)
      ST_IDLE:  if (w_grant) w_state_nxt = ST_BEAT0;
      ST_BEAT0: if (w_push0) w_state_nxt = ST_BEAT1;
      ST_BEAT1: if (w_push1) w_state_nxt = w_grant ? ST_BEAT0 : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    af_addr_din  = r_addr;
    af_wr_en     = w_push0;
    wdf_wr_en    = w_push0 | w_push1;
    wdf_din      = r_data[2*DATA_W-1:DATA_W];
    wdf_mask_din = '1;
    case (r_state)
      ST_BEAT0: wdf_mask_din = r_mask[2*MASK_W-1:MASK_W];
      ST_BEAT1: begin
        wdf_din      = r_data[DATA_W-1:0];
        wdf_mask_din = r_mask[MASK_W-1:0];
      end
      default: ;
    endcase
    r0_ack = w_grant & ~w_gnt_sel;
    r1_ack = w_grant &  w_gnt_sel;
    busy   = (r_state != ST_IDLE);
    gnt_id = r_gnt_id;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_gnt_id <= 1'b0;
      // NOTE: payload registers are reset because they drive af_addr_din/wdf_din directly.
      r_addr   <= '0;
      r_data   <= '0;
      r_mask   <= '1;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_last   <= w_gnt_sel;
        r_gnt_id <= w_gnt_sel;
        r_addr   <= w_gnt_sel ? r1_addr : r0_addr;
        r_data   <= w_gnt_sel ? r1_data : r0_data;
        r_mask   <= w_gnt_sel ? r1_mask : r0_mask;
      end
    end
  end

`ifdef WRARB_PERF_CNT_EN
  logic w_stall;
  assign w_stall = ((r_state == ST_BEAT0) & (af_full | wdf_full)) |
                   ((r_state == ST_BEAT1) & wdf_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_burst_cnt <= '0;
      r1_burst_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (w_push1 & ~r_gnt_id) r0_burst_cnt <= r0_burst_cnt + 32'd1;
      if (w_push1 &  r_gnt_id) r1_burst_cnt <= r1_burst_cnt + 32'd1;
      if (w_stall)             stall_cnt    <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wr_fifo_arbiter.sv
// Directed self-checking bench for wr_fifo_arbiter: single burst, fairness, full stalls, mid-burst reset.
module tb_wr_fifo_arbiter;
  localparam int ADDR_W = 31;
  localparam int DATA_W = 128;
  localparam int MASK_W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                r0_valid, r1_valid;
  logic [ADDR_W-1:0]   r0_addr, r1_addr;
  logic [2*DATA_W-1:0] r0_data, r1_data;
  logic [2*MASK_W-1:0] r0_mask, r1_mask;
  logic                r0_ack, r1_ack;
  logic                af_full, wdf_full;
  logic [ADDR_W-1:0]   af_addr_din;
  logic                af_wr_en;
  logic [DATA_W-1:0]   wdf_din;
  logic [MASK_W-1:0]   wdf_mask_din;
  logic                wdf_wr_en;
  logic                busy, gnt_id;
`ifdef WRARB_PERF_CNT_EN
  logic [31:0]         r0_burst_cnt, r1_burst_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0]   pa[2];
  logic [2*DATA_W-1:0] pd[2];
  logic [2*MASK_W-1:0] pm[2];

  always #5 clk = ~clk;

  wr_fifo_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_data(r0_data), .r0_mask(r0_mask), .r0_ack(r0_ack),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_data(r1_data), .r1_mask(r1_mask), .r1_ack(r1_ack),
    .af_full(af_full), .wdf_full(wdf_full),
    .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
    .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
`ifdef WRARB_PERF_CNT_EN
    .r0_burst_cnt(r0_burst_cnt), .r1_burst_cnt(r1_burst_cnt), .stall_cnt(stall_cnt),
`endif
    .busy(busy), .gnt_id(gnt_id)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One isolated burst from requester 'who' with optional stall cycles injected.
  task automatic do_burst(input int who, input int n_af, input int n_wdf0, input int n_wdf1);
    logic [2*DATA_W-1:0] d;
    logic [2*MASK_W-1:0] m;
    d = pd[who];
    m = pm[who];
    next_cycle();
    r0_valid = (who == 0);
    r1_valid = (who == 1);
    af_full = 1'b0;
    wdf_full = 1'b0;
    @(negedge clk);
    check("idle_ack0", r0_ack, (who == 0));
    check("idle_ack1", r1_ack, (who == 1));
    check("idle_af_en", af_wr_en, 1'b0);
    check("idle_busy", busy, 1'b0);
    for (int i = 0; i < n_af + n_wdf0; i++) begin
      next_cycle();
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      af_full  = (i < n_af);
      wdf_full = (i >= n_af);
      @(negedge clk);
      check("b0_stall_af_en", af_wr_en, 1'b0);
      check("b0_stall_wdf_en", wdf_wr_en, 1'b0);
      check("b0_stall_addr", af_addr_din, pa[who]);
      check("b0_stall_mask", wdf_mask_din, m[31:16]);
      check("b0_stall_busy", busy, 1'b1);
    end
    next_cycle();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    af_full  = 1'b0;
    wdf_full = 1'b0;
    @(negedge clk);
    check("b0_af_en", af_wr_en, 1'b1);
    check("b0_wdf_en", wdf_wr_en, 1'b1);
    check("b0_addr", af_addr_din, pa[who]);
    check("b0_din", wdf_din, d[255:128]);
    check("b0_mask", wdf_mask_din, m[31:16]);
    check("b0_gnt_id", gnt_id, who[0]);
    for (int i = 0; i < n_wdf1; i++) begin
      next_cycle();
      wdf_full = 1'b1;
      @(negedge clk);
      check("b1_stall_wdf_en", wdf_wr_en, 1'b0);
      check("b1_stall_af_en", af_wr_en, 1'b0);
      check("b1_stall_din", wdf_din, d[127:0]);
    end
    next_cycle();
    wdf_full = 1'b0;
    @(negedge clk);
    check("b1_wdf_en", wdf_wr_en, 1'b1);
    check("b1_af_en", af_wr_en, 1'b0);
    check("b1_din", wdf_din, d[127:0]);
    check("b1_mask", wdf_mask_din, m[15:0]);
    check("b1_no_ack", {r0_ack, r1_ack}, 2'b00);
    next_cycle();
    @(negedge clk);
    check("end_idle_en", {af_wr_en, wdf_wr_en}, 2'b00);
    check("end_idle_busy", busy, 1'b0);
    check("end_idle_mask", wdf_mask_din, 16'hFFFF);
  endtask

  initial begin
    pa[0] = 31'h0010_0040;
    pa[1] = 31'h0020_0080;
    pd[0] = {{4{32'hA0A0_0001}}, {4{32'hB0B0_0002}}};
    pd[1] = {{4{32'hC0C0_0003}}, {4{32'hD0D0_0004}}};
    pm[0] = {16'h0FFF, 16'hFFFF};
    pm[1] = {16'h00F0, 16'h8001};
    r0_addr = pa[0]; r0_data = pd[0]; r0_mask = pm[0];
    r1_addr = pa[1]; r1_data = pd[1]; r1_mask = pm[1];
    af_full = 1'b0;
    wdf_full = 1'b0;
    r0_valid = 1'b1;
    r1_valid = 1'b0;
    rst = 1'b1;

    // Reset state, with a valid request present that must not be acked.
    #3;
    check("rst_af_en", af_wr_en, 1'b0);
    check("rst_wdf_en", wdf_wr_en, 1'b0);
    check("rst_acks", {r0_ack, r1_ack}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_gnt_id", gnt_id, 1'b0);
    check("rst_addr", af_addr_din, '0);
    check("rst_din", wdf_din, '0);
    check("rst_mask", wdf_mask_din, 16'hFFFF);
    next_cycle();
    next_cycle();
    r0_valid = 1'b0;
    rst = 1'b0;

    // Fairness: both valid for 8 bursts, r0 wins the first tie.
    next_cycle();
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    @(negedge clk);
    check("rr_first_ack0", r0_ack, 1'b1);
    check("rr_first_ack1", r1_ack, 1'b0);
    for (int n = 0; n < 8; n++) begin
      logic [2*DATA_W-1:0] d;
      int g;
      g = n % 2;
      d = pd[g];
      next_cycle();
      @(negedge clk);
      check("rr_b0_af_en", af_wr_en, 1'b1);
      check("rr_b0_addr", af_addr_din, pa[g]);
      check("rr_b0_gnt", gnt_id, g[0]);
      check("rr_b0_din", wdf_din, d[255:128]);
      next_cycle();
      if (n == 7) begin
        r0_valid = 1'b0;
        r1_valid = 1'b0;
      end
      @(negedge clk);
      check("rr_b1_wdf_en", wdf_wr_en, 1'b1);
      check("rr_b1_af_en", af_wr_en, 1'b0);
      check("rr_b1_din", wdf_din, d[127:0]);
      check("rr_b1_ack_next", (g == 0) ? r1_ack : r0_ack, (n != 7));
      check("rr_b1_ack_same", (g == 0) ? r0_ack : r1_ack, 1'b0);
    end
    next_cycle();
    @(negedge clk);
    check("rr_end_busy", busy, 1'b0);
    check("rr_end_en", {af_wr_en, wdf_wr_en}, 2'b00);

    // Plain single r0 burst, then r1 with af_full x3, wdf_full in BEAT0 x1, wdf_full in BEAT1 x2.
    do_burst(0, 0, 0, 0);
    do_burst(1, 3, 1, 2);

    // Reset asserted mid-BEAT1.
    do_burst(0, 0, 0, 0);
    next_cycle();
    r0_valid = 1'b1;
    @(negedge clk);
    check("mr_ack0", r0_ack, 1'b1);
    next_cycle();
    r0_valid = 1'b0;
    @(negedge clk);
    check("mr_b0_push", af_wr_en, 1'b1);
    next_cycle();
    #1;
    check("mr_b1_push", wdf_wr_en, 1'b1);
    rst = 1'b1;
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    #1;
    check("mr_rst_en", {af_wr_en, wdf_wr_en}, 2'b00);
    check("mr_rst_mask", wdf_mask_din, 16'hFFFF);
    check("mr_rst_busy", busy, 1'b0);
    check("mr_rst_acks", {r0_ack, r1_ack}, 2'b00);
    check("mr_rst_din", wdf_din, '0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mr_post_ack0", r0_ack, 1'b1);
    check("mr_post_ack1", r1_ack, 1'b0);
    next_cycle();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    @(negedge clk);
    check("mr_post_addr", af_addr_din, pa[0]);
    check("mr_post_gnt", gnt_id, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("mr_post_idle", busy, 1'b0);

`ifdef WRARB_PERF_CNT_EN
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    check("pc_rst_r0", r0_burst_cnt, 32'd0);
    do_burst(0, 2, 0, 0);
    do_burst(1, 0, 0, 2);
    do_burst(0, 0, 0, 0);
    do_burst(1, 0, 0, 0);
    do_burst(0, 0, 0, 0);
    check("pc_r0", r0_burst_cnt, 32'd3);
    check("pc_r1", r1_burst_cnt, 32'd2);
    check("pc_stall", stall_cnt, 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wr_fifo_arbiter.md
Name: wr_fifo_arbiter

Overview:
- Shares the DDR write path (address FIFO af_*, write-data FIFO wdf_*) between two burst requesters.
- Requester 0 is the line engine; requester 1 is the frame-clear/fill path.
- Each request is one atomic write burst: one address plus two 128-bit data beats with per-beat byte masks.
- The block arbitrates round-robin, latches the winning burst, and sequences it into the FIFOs while honouring af_full and wdf_full.

Parameters:
- ADDR_W, 31, address width, matches af_addr_din.
- DATA_W, 128, width of one data beat.
- MASK_W, 16, byte-mask width per beat (DATA_W/8).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- r0_valid  in  1  requester 0 holds a burst
- r0_addr  in  ADDR_W  burst address
- r0_data  in  2*DATA_W  beat0 = [2*DATA_W-1:DATA_W], beat1 = [DATA_W-1:0]
- r0_mask  in  2*MASK_W  beat0 mask = upper half; 1 = byte not written
- r0_ack  out  1  one-cycle pulse: burst latched, requester may change inputs next cycle
- r1_valid, r1_addr, r1_data, r1_mask, r1_ack  same as r0_*, for requester 1
- af_full  in  1  address FIFO full
- wdf_full  in  1  write-data FIFO full
- af_addr_din  out  ADDR_W  address to FIFO
- af_wr_en  out  1  address FIFO push
- wdf_din  out  DATA_W  data beat
- wdf_mask_din  out  MASK_W  beat mask
- wdf_wr_en  out  1  data FIFO push
- busy  out  1  burst in flight (state != IDLE)
- gnt_id  out  1  owner of the current or last burst

Behaviour:
- Reset (async, rst=1), applied immediately:
  - state=IDLE; af_wr_en=0; wdf_wr_en=0; r0_ack=r1_ack=0; busy=0; gnt_id=0.
  - af_addr_din=0; wdf_din=0; wdf_mask_din=all ones.
  - last-grant pointer=1, so r0 wins the first tie.
- States: IDLE, BEAT0, BEAT1.
- Arbitration happens in IDLE, or in BEAT1 in the cycle its push completes (back-to-back bursts):
  - Only one valid: grant it.
  - Both valid: grant the requester that is not the last-granted one.
  - Grant: latch addr/data/mask, pulse that requester's ack for one cycle, update the pointer and gnt_id, next state BEAT0.
  - No valid: next state IDLE.
- BEAT0:
  - af_addr_din = latched addr; wdf_din = beat0; wdf_mask_din = beat0 mask.
  - af_wr_en = wdf_wr_en = ~af_full & ~wdf_full, combinational on the fulls.
  - The push occurs when both enables are high; then go to BEAT1. Otherwise hold state and outputs.
  - The address and the first data beat are never pushed separately.
- BEAT1:
  - wdf_din = beat1; wdf_mask_din = beat1 mask; af_wr_en = 0.
  - wdf_wr_en = ~wdf_full.
  - On push: arbitrate as above. Otherwise hold.
- Outside BEAT0/BEAT1: both write enables are 0 and wdf_mask_din = all ones.
- Timing:
  - Latency from valid (arbiter in IDLE) to the af push cycle is 1 cycle minimum.
  - Sustained throughput is 2 cycles per burst when the FIFOs are not full.
- Requester rules:
  - Requesters hold valid and payload stable until ack.
  - valid sampled in the cycle after ack is treated as a new burst.
  - Dropping valid before ack withdraws the request; it is legal and nothing is latched.
- Fairness: while both requesters stay valid, grants strictly alternate. Neither requester waits more than one burst.
- Reset mid-burst aborts the burst. Any unpushed beats are lost. No partial re-issue after reset.

Optional Feature:
- Macro: WRARB_PERF_CNT_EN.
- Defined:
  - Adds outputs r0_burst_cnt[31:0], r1_burst_cnt[31:0] (completed bursts per requester, incremented on the BEAT1 push).
  - Adds stall_cnt[31:0]: cycles spent in BEAT0/BEAT1 with the enable blocked by a full flag.
  - All counters wrap and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single burst, fulls low: r0_valid with addr=0x0010_0040, beat0 mask=0x0FFF, beat1 mask=0xFFFF.
  - Expect r0_ack on cycle 1, af_wr_en+wdf_wr_en with that addr and mask on cycle 2, wdf_wr_en only on cycle 3, then idle.
- r0 and r1 continuously valid for 4 bursts each.
  - Expect grant order r0,r1,r0,r1,...; push every 2 cycles, no idle gap; gnt_id alternating.
- af_full high for 3 cycles during BEAT0.
  - Expect af_wr_en=wdf_wr_en=0 and outputs held for those 3 cycles; push in the cycle af_full falls.
  - With wdf_full high and af_full low, still no push.
- wdf_full high for 2 cycles in BEAT1.
  - Expect wdf_wr_en=0, beat1 held; then one push; no extra af push.
- rst asserted mid-BEAT1.
  - Expect all enables 0 in the same cycle, mask all ones, busy=0.
  - After release with both valid, r0 is granted first.
- With WRARB_PERF_CNT_EN: 3 r0 bursts, 2 r1 bursts, 4 full-stall cycles.
  - Expect r0_burst_cnt=3, r1_burst_cnt=2, stall_cnt=4.
